// File: rtl/edge_pkg.sv
// Shared definitions for the streaming Sobel edge detector: mode codes,
// gradient width derivation and the scale-and-saturate helper.
package edge_pkg;

    localparam logic [1:0] MODE_MAG = 2'd0;
    localparam logic [1:0] MODE_GX  = 2'd1;
    localparam logic [1:0] MODE_GY  = 2'd2;
    localparam logic [1:0] MODE_BIN = 2'd3;

    // Weighted sums reach 4*(2^PIX_W-1), so a sign bit plus two guard bits suffice.
    localparam int GRAD_GUARD = 32'sd3;

    function automatic int grad_w(input int pix_w);
        return pix_w + GRAD_GUARD;
    endfunction

    function automatic logic [31:0] sat_shift(input logic [31:0] value, input int pix_w);
        logic [31:0] shifted;
        logic [31:0] max_val;
        shifted = value >> 2;
        max_val = (32'd1 << pix_w) - 32'd1;
        if (shifted > max_val) begin
            return max_val;
        end else begin
            return shifted;
        end
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-port line store: combinational read of the addressed entry, write on
// enable, so a same-cycle read always sees the previous contents.
module line_buffer #(
    parameter int DEPTH  = 640,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              En,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [WIDTH-1:0]  WrData,
    output logic [WIDTH-1:0]  RdData
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    assign RdData = mem_r[Addr];

    // Storage write; contents are deliberately not reset
    always_ff @(posedge Clk) begin
        if (En) begin
            mem_r[Addr] <= WrData;
        end
    end

endmodule

// File: rtl/edge_sobel_stream.sv
// Streaming 3x3 Sobel filter: two line buffers feed a 3x3 window, gradients are
// registered, then the selected mode result is saturated and border-masked.
module edge_sobel_stream
    import edge_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int LINE_W = 640,
    parameter int COL_W  = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             InValid,
    input  logic             InSof,
    input  logic [PIX_W-1:0] PixelIn,
    input  logic [1:0]       Mode,
    input  logic [PIX_W-1:0] Thresh,
    output logic             OutValid,
    output logic             OutSof,
    output logic [PIX_W-1:0] PixelOut
);

    localparam int GW = grad_w(PIX_W);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);
    localparam logic [COL_W-1:0] COL_ONE  = {{(COL_W-1){1'b0}}, 1'b1};
    localparam logic [COL_W-1:0] COL_TWO  = {{(COL_W-2){1'b0}}, 2'b10};
    localparam logic [PIX_W-1:0] PIX_ZERO = {PIX_W{1'b0}};
    localparam logic [PIX_W-1:0] PIX_MAX  = {PIX_W{1'b1}};

    logic             accept_s;
    logic [COL_W-1:0] col_r, col_eff_s, col_nxt_s;
    logic [1:0]       row_r, row_eff_s, row_nxt_s;
    logic [1:0]       mode_r, mode_eff_s;
    logic [PIX_W-1:0] thresh_r, thresh_eff_s;
    logic [PIX_W-1:0] lb1_rd_s, lb2_rd_s;
    logic [PIX_W-1:0] win_r [3][3];

    logic             v0_r, sof0_r, inner0_r;
    logic [1:0]       mode0_r;
    logic [PIX_W-1:0] thresh0_r;
    logic [GW-1:0]    gx_pos_s, gx_neg_s, gy_pos_s, gy_neg_s;
    logic signed [GW-1:0] gx_s, gy_s;
    logic [GW-2:0]    agx_s, agy_s;

    logic             v1_r, sof1_r, inner1_r;
    logic [1:0]       mode1_r;
    logic [PIX_W-1:0] thresh1_r;
    logic [GW-2:0]    agx_r, agy_r;
    logic [PIX_W-1:0] mag_s, result_s;

    // Frame position, per-frame settings and next position of the incoming pixel
    always_comb begin
        accept_s  = En && InValid;
        col_nxt_s = {COL_W{1'b0}};
        row_nxt_s = 2'd0;
        if (InSof) begin
            col_eff_s    = {COL_W{1'b0}};
            row_eff_s    = 2'd0;
            mode_eff_s   = Mode;
            thresh_eff_s = Thresh;
        end else begin
            col_eff_s    = col_r;
            row_eff_s    = row_r;
            mode_eff_s   = mode_r;
            thresh_eff_s = thresh_r;
        end
        if (col_eff_s == LAST_COL) begin
            col_nxt_s = {COL_W{1'b0}};
            row_nxt_s = (row_eff_s == 2'd2) ? 2'd2 : row_eff_s + 2'd1;
        end else begin
            col_nxt_s = col_eff_s + COL_ONE;
            row_nxt_s = row_eff_s;
        end
    end

    // Position counters and frame-latched mode/threshold
    always_ff @(posedge Clk) begin
        if (Reset) begin
            col_r    <= {COL_W{1'b0}};
            row_r    <= 2'd0;
            mode_r   <= MODE_MAG;
            thresh_r <= PIX_ZERO;
        end else if (accept_s) begin
            col_r    <= col_nxt_s;
            row_r    <= row_nxt_s;
            mode_r   <= mode_eff_s;
            thresh_r <= thresh_eff_s;
        end
    end

    // lb1 holds row r-1, lb2 row r-2; the old r-1 entry cascades into lb2
    line_buffer #(.DEPTH(LINE_W), .WIDTH(PIX_W), .ADDR_W(COL_W)) u_lb1 (
        .Clk(Clk), .En(accept_s), .Addr(col_eff_s), .WrData(PixelIn), .RdData(lb1_rd_s)
    );
    line_buffer #(.DEPTH(LINE_W), .WIDTH(PIX_W), .ADDR_W(COL_W)) u_lb2 (
        .Clk(Clk), .En(accept_s), .Addr(col_eff_s), .WrData(lb1_rd_s), .RdData(lb2_rd_s)
    );

    // Window shift: column 2 takes the fresh column, older columns move left
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_r[i][j] <= PIX_ZERO;
                end
            end
        end else if (accept_s) begin
            for (int i = 0; i < 3; i++) begin
                win_r[i][0] <= win_r[i][1];
                win_r[i][1] <= win_r[i][2];
            end
            win_r[0][2] <= lb2_rd_s;
            win_r[1][2] <= lb1_rd_s;
            win_r[2][2] <= PixelIn;
        end
    end

    // Stage 0 control travelling alongside the window
    always_ff @(posedge Clk) begin
        if (Reset) begin
            v0_r      <= 1'b0;
            sof0_r    <= 1'b0;
            inner0_r  <= 1'b0;
            mode0_r   <= MODE_MAG;
            thresh0_r <= PIX_ZERO;
        end else if (En) begin
            v0_r      <= accept_s;
            sof0_r    <= accept_s && InSof;
            inner0_r  <= (row_eff_s == 2'd2) && (col_eff_s >= COL_TWO);
            mode0_r   <= mode_eff_s;
            thresh0_r <= thresh_eff_s;
        end
    end

    // Sobel kernels on the current window and their absolute values
    always_comb begin
        gx_pos_s = GW'(win_r[0][2]) + GW'({win_r[1][2], 1'b0}) + GW'(win_r[2][2]);
        gx_neg_s = GW'(win_r[0][0]) + GW'({win_r[1][0], 1'b0}) + GW'(win_r[2][0]);
        gy_pos_s = GW'(win_r[2][0]) + GW'({win_r[2][1], 1'b0}) + GW'(win_r[2][2]);
        gy_neg_s = GW'(win_r[0][0]) + GW'({win_r[0][1], 1'b0}) + GW'(win_r[0][2]);
        gx_s     = gx_pos_s - gx_neg_s;
        gy_s     = gy_pos_s - gy_neg_s;
        if (gx_s[GW-1]) begin
            agx_s = (GW-1)'(-gx_s);
        end else begin
            agx_s = (GW-1)'(gx_s);
        end
        if (gy_s[GW-1]) begin
            agy_s = (GW-1)'(-gy_s);
        end else begin
            agy_s = (GW-1)'(gy_s);
        end
    end

    // Stage 1: registered gradient magnitudes
    always_ff @(posedge Clk) begin
        if (Reset) begin
            v1_r      <= 1'b0;
            sof1_r    <= 1'b0;
            inner1_r  <= 1'b0;
            mode1_r   <= MODE_MAG;
            thresh1_r <= PIX_ZERO;
            agx_r     <= {(GW-1){1'b0}};
            agy_r     <= {(GW-1){1'b0}};
        end else if (En) begin
            v1_r      <= v0_r;
            sof1_r    <= sof0_r;
            inner1_r  <= inner0_r;
            mode1_r   <= mode0_r;
            thresh1_r <= thresh0_r;
            agx_r     <= agx_s;
            agy_r     <= agy_s;
        end
    end

    // Mode selection with saturation; border pixels are forced to zero
    always_comb begin
        mag_s    = PIX_W'(sat_shift(32'(agx_r) + 32'(agy_r), PIX_W));
        result_s = PIX_ZERO;
        if (inner1_r) begin
            case (mode1_r)
                MODE_MAG: result_s = mag_s;
                MODE_GX:  result_s = PIX_W'(sat_shift(32'(agx_r), PIX_W));
                MODE_GY:  result_s = PIX_W'(sat_shift(32'(agy_r), PIX_W));
                MODE_BIN: result_s = (mag_s >= thresh1_r) ? PIX_MAX : PIX_ZERO;
                default:  result_s = PIX_ZERO;
            endcase
        end else begin
            result_s = PIX_ZERO;
        end
    end

    // Stage 2: output register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            OutValid <= 1'b0;
            OutSof   <= 1'b0;
            PixelOut <= PIX_ZERO;
        end else if (En) begin
            OutValid <= v1_r;
            OutSof   <= sof1_r;
            PixelOut <= result_s;
        end
    end

endmodule

// File: tb/tb_edge_sobel_stream.sv
// Randomized bench for edge_sobel_stream: frames are stored as images and each
// output is recomputed from the image with plain Sobel arithmetic.
module tb_edge_sobel_stream;

    localparam int PIX_W  = 8;
    localparam int LINE_W = 8;
    localparam int COL_W  = 3;
    localparam int ROWS_MAX = 16;

    logic       Clk = 1'b0;
    logic       Reset, En, InValid, InSof;
    logic [7:0] PixelIn, Thresh;
    logic [1:0] Mode;
    logic       OutValid, OutSof;
    logic [7:0] PixelOut;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit sof;
        int pix;
    } exp_t;

    exp_t exp_q[$];
    int   img [ROWS_MAX][LINE_W];
    int   m_row, m_col, m_mode, m_thr;
    bit   stall_on;

    logic en_edge  = 1'b0;
    logic rst_edge = 1'b1;
    logic pv_valid, pv_sof;
    logic [7:0] pv_pix;

    always #5 Clk = ~Clk;

    edge_sobel_stream #(.PIX_W(PIX_W), .LINE_W(LINE_W), .COL_W(COL_W)) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .InValid(InValid), .InSof(InSof),
        .PixelIn(PixelIn), .Mode(Mode), .Thresh(Thresh),
        .OutValid(OutValid), .OutSof(OutSof), .PixelOut(PixelOut)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clip(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Filter result for the pixel whose bottom-right window corner is (r, c)
    function automatic int ref_pix(input int r, input int c);
        int gx, gy, ax, ay, mag;
        if (r < 2 || c < 2) return 0;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c]) - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c]) - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        mag = clip((ax + ay) / 4);
        case (m_mode)
            0:       return mag;
            1:       return clip(ax / 4);
            2:       return clip(ay / 4);
            default: return (mag >= m_thr) ? 255 : 0;
        endcase
    endfunction

    task automatic model_accept(input int pix, input bit sof);
        if (sof) begin
            m_row  = 0;
            m_col  = 0;
            m_mode = Mode;
            m_thr  = Thresh;
        end
        img[m_row][m_col] = pix;
        exp_q.push_back('{sof, ref_pix(m_row, m_col)});
        if (m_col == LINE_W - 1) begin
            m_col = 0;
            m_row++;
        end else begin
            m_col++;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            En = 1'b1; InValid = 1'b0; InSof = 1'b0; PixelIn = 8'($urandom);
            tick();
        end
    endtask

    task automatic push(input int pix, input bit sof);
        int n;
        if (stall_on) begin
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) begin
                En      = 1'($urandom_range(0, 1));
                InValid = En ? 1'b0 : 1'($urandom_range(0, 1));
                InSof   = 1'($urandom_range(0, 1));
                PixelIn = 8'($urandom);
                tick();
            end
        end
        En = 1'b1; InValid = 1'b1; InSof = sof; PixelIn = 8'(pix);
        @(posedge Clk);
        model_accept(pix, sof);
        #1;
    endtask

    // kind: 0 flat 100, 1 vertical step, 2 saturation corner, 3 random, 4 all 255, 5 all 0
    function automatic int gen_pix(input int kind, input int r, input int c);
        case (kind)
            0:       return 100;
            1:       return (c >= 4) ? 200 : 0;
            2:       return ((r == 1 && c == 2) || (r == 2 && (c == 1 || c == 2))) ? 255 : 0;
            3:       return int'($urandom_range(0, 255));
            4:       return 255;
            default: return 0;
        endcase
    endfunction

    task automatic send_frame(input int kind, input int rows, input bit change_mid);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < LINE_W; c++) begin
                if (change_mid && r == 1 && c == 2) begin
                    Mode   = 2'd0;
                    Thresh = 8'd0;
                end
                push(gen_pix(kind, r, c), (r == 0 && c == 0));
            end
        end
    endtask

    task automatic drain_and_check(input string tag);
        idle_cycles(5);
        check_val(tag, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        Reset = 1'b1; En = 1'b0; InValid = 1'b1; InSof = 1'b0;
        tick();
        exp_q.delete();
        m_row = 0; m_col = 0; m_mode = 0; m_thr = 0;
        check_val("rst_valid", OutValid, 0);
        check_val("rst_sof", OutSof, 0);
        check_val("rst_pix", PixelOut, 0);
        Reset = 1'b0; InValid = 1'b0;
    endtask

    always @(posedge Clk) begin
        en_edge  <= En;
        rst_edge <= Reset;
    end

    // Output monitor: pops expectations on enabled edges, checks holds otherwise
    always @(negedge Clk) begin
        exp_t e;
        if (!rst_edge) begin
            if (!en_edge) begin
                check_val("hold_valid", OutValid, pv_valid);
                check_val("hold_sof", OutSof, pv_sof);
                check_val("hold_pix", PixelOut, pv_pix);
            end else if (OutValid) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("pix", PixelOut, e.pix);
                    check_val("sof", OutSof, e.sof);
                end
            end
        end
        pv_valid = OutValid;
        pv_sof   = OutSof;
        pv_pix   = PixelOut;
    end

    initial begin
        int n;
        Reset = 1'b1; En = 1'b0; InValid = 1'b0; InSof = 1'b0; PixelIn = 8'd0;
        Mode = 2'd0; Thresh = 8'd0; stall_on = 1'b0;
        m_row = 0; m_col = 0; m_mode = 0; m_thr = 0;
        tick();
        do_reset();

        Mode = 2'd0; send_frame(0, 3, 1'b0); drain_and_check("flat_count");
        Mode = 2'd0; send_frame(1, 4, 1'b0); drain_and_check("step_mag_count");
        Mode = 2'd2; send_frame(1, 4, 1'b0); drain_and_check("step_gy_count");
        Mode = 2'd3; Thresh = 8'd150; send_frame(1, 4, 1'b0); drain_and_check("bin150_count");
        Mode = 2'd3; Thresh = 8'd201; send_frame(1, 4, 1'b0); drain_and_check("bin201_count");
        Mode = 2'd3; Thresh = 8'd150; send_frame(1, 4, 1'b1); drain_and_check("mode_latch_count");
        Mode = 2'd1; send_frame(1, 4, 1'b0); drain_and_check("step_gx_count");
        Mode = 2'd0; send_frame(2, 3, 1'b0); drain_and_check("sat_count");

        // Reset mid-frame with stale 255 data, then a dark frame
        Mode = 2'd1;
        for (int i = 0; i < 20; i++) push(255, i == 0);
        do_reset();
        En = 1'b0; tick();
        check_val("lat_pre", OutValid, 0);
        Mode = 2'd0;
        push(0, 1'b1); check_val("lat_c1", OutValid, 0);
        push(0, 1'b0); check_val("lat_c2", OutValid, 0);
        push(0, 1'b0); check_val("lat_c3", OutValid, 1);
        for (int i = 3; i < 3 * LINE_W; i++) push(0, 1'b0);
        drain_and_check("post_reset_count");

        // Random frames with stalls, bubbles, early frame starts and mid-frame mode changes
        stall_on = 1'b1;
        for (int f = 0; f < 8; f++) begin
            Mode   = 2'($urandom_range(0, 3));
            Thresh = 8'($urandom_range(0, 255));
            n      = (f == 3) ? 13 : LINE_W * int'($urandom_range(3, 5));
            for (int i = 0; i < n; i++) begin
                if (f == 0 && i == 20) begin
                    En = 1'b0; InValid = 1'b1;
                    for (int k = 0; k < 5; k++) begin
                        InSof = 1'($urandom_range(0, 1)); PixelIn = 8'($urandom);
                        tick();
                    end
                end
                if ($urandom_range(0, 19) == 0) begin
                    Mode   = 2'($urandom_range(0, 3));
                    Thresh = 8'($urandom_range(0, 255));
                end
                push(gen_pix(3, 0, 0), i == 0);
            end
        end
        stall_on = 1'b0;
        drain_and_check("random_count");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_sobel_stream.md
# edge_sobel_stream

Parametrised streaming 3×3 Sobel edge detector for the VGA pixel path, sitting between the capture/greyscale stage and the display buffer. It accepts one pixel per enabled valid cycle in raster order. It produces one filtered pixel per accepted input, in one of four modes: gradient magnitude, horizontal gradient, vertical gradient, or thresholded binary. This is the next generation of the single-mode edge block, adding:
- a configurable pixel width and line length
- valid/start-of-frame framing
- border masking
- saturation
- a run-time mode select

## Interface
- PIX_W, 8: pixel width in bits (input and output).
- LINE_W, 640: pixels per line; line buffer depth.
- COL_W, 10: column counter width; must satisfy 2^COL_W ≥ LINE_W.
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- En  in  1  pipeline enable; when low, all state holds.
- InValid  in  1  PixelIn/InSof are valid this cycle.
- InSof  in  1  first pixel of a frame (row 0, col 0).
- PixelIn  in  PIX_W  unsigned input pixel.
- Mode  in  2  0 = magnitude, 1 = |Gx|, 2 = |Gy|, 3 = binary threshold.
- Thresh  in  PIX_W  binary-mode threshold.
- OutValid  out  1  PixelOut/OutSof are valid.
- OutSof  out  1  first output of a frame.
- PixelOut  out  PIX_W  filtered pixel.

## Operation
- **Accept condition:** a pixel is accepted when En && InValid; nothing else advances the counters or line buffers.
- **Counters:** col counts 0..LINE_W-1 and wraps to 0, incrementing row. The row count saturates at 2; only the flag row ≥ 2 is needed.
- **Start of frame:** an accepted InSof forces col = 0 and row = 0 for that pixel. This applies also mid-line or mid-frame, with no error.
- **Line buffers:** two circular line buffers, each LINE_W × PIX_W, indexed by col, hold rows r-1 and r-2. Each accept performs a read and a write at the same address: the old row r-1 value moves into row r-2 and PixelIn is written as the new row r-1.
- **Window:** three 3-deep shift registers (one per row) form the window. The bottom-right of the window is the current input; the output refers to the centre pixel (r-1, c-1).
- **Kernels:**
  - Gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20)
  - Gy = (p20 + 2·p21 + p22) − (p00 + 2·p01 + p02)
  - Both are signed, PIX_W+3 bits; take the absolute values.
- **Output scaling:** the magnitude is (|Gx| + |Gy|) >> 2. Modes 1 and 2 use |Gx| >> 2 and |Gy| >> 2 respectively. All results saturate to 2^PIX_W − 1.
- **Binary mode (Mode 3):** output is all-ones when the magnitude ≥ Thresh, otherwise 0.
- **Border masking:** if row < 2 or col < 2 at accept time, the output is forced to 0. This also masks stale line-buffer data after reset or an early InSof.
- **Mode/Thresh latching:** Mode and Thresh are latched on an accepted InSof and held for the whole frame. Changes mid-frame have no effect until the next InSof.
- **Reset:** OutValid = 0, OutSof = 0, PixelOut = 0; counters, row flag, latched mode (= 0) and latched threshold (= 0) are cleared. Line buffer RAM is not cleared.

## Timing
- **Pipeline:** 3 enabled stages:
  - S0: line-buffer read and window shift.
  - S1: |Gx| and |Gy| registered.
  - S2: mode select, saturate, output register.
- **Latency:** OutValid rises 3 enabled cycles after the accepting cycle. OutSof travels with its pixel.
- **Stalls:** when En = 0, all pipeline registers, counters and outputs hold their values, including OutValid. No pixel is lost or duplicated.
- **Bubbles:** InValid = 0 with En = 1 inserts a bubble, giving OutValid = 0 three cycles later.
- **Throughput:** one pixel per cycle; no backpressure output.
- **Read-during-write:** the line buffer must return the old data.
- **Reset priority:** Reset has priority over En; in-flight pixels are discarded.

## Structure
- **Shared package edge_pkg:**
  - mode constants MODE_MAG, MODE_GX, MODE_GY, MODE_BIN;
  - a saturate-and-shift function;
  - the signed gradient width derivation (PIX_W+3).
- **Sub-module line_buffer:** parametrised single-port read-before-write RAM (depth LINE_W, width PIX_W, enable input). It is instantiated twice.
- **Top level:** the remaining logic (counters, window, kernels, output) lives in edge_sobel_stream.

## Test plan
1. Flat frame, LINE_W = 8, all pixels 100, Mode 0 → every PixelOut = 0; OutValid count equals input count; OutSof on the first output only.
2. Vertical step (cols 0–3 = 0, cols 4–7 = 200), 4 rows, Mode 0 → rows ≥ 2, outputs at col indices 4 and 5 (centres 3, 4) = 200, all others 0. Mode 2 → all outputs 0.
3. Same stimulus in Mode 3:
   - Thresh = 150 → 255 at those positions, 0 elsewhere.
   - Thresh = 201 → all 0.
   - A Mode change mid-frame is ignored until the next InSof.
4. Saturation: window [0 0 0; 0 0 255; 0 255 255] → Gx = Gy = 765, (1530 >> 2) = 382 → PixelOut = 255.
5. Stall: randomly deassert En (including 5 consecutive cycles mid-line) and insert InValid bubbles → the output pixel sequence is identical to the unstalled run, and outputs hold while En = 0.
6. Reset mid-frame (with the line buffers full of 255), then a new frame of all 0 → every output 0, OutValid low for 3 cycles after the first accept, and no stale edges.
